// File: rtl/opl_timer_status.sv
// opl_timer_status: OPL2 timer register/status stage.
// Decodes host writes to regs 0x02 (timer 1 preset), 0x03 (timer 2 preset)
// and 0x04 (IRQ reset / masks / starts), and turns the timer overflow levels
// into the sticky FT1/FT2/IRQ bits of the status byte.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr, addr, din       host register write strobe, address, data
//   overflow1/2         overflow levels from the two timers
//   timer1_init/2_init  timer preset values (regs 0x02/0x03)
//   start1/2            timer run enables (reg 0x04 bits 0/1)
//   status              {irq, ft1, ft2, 5'b0}
//   irq_n               active-low interrupt pin (only with OPL_IRQ_PIN_EN)
//
// Configuration macro: OPL_IRQ_PIN_EN adds the registered irq_n output.
// TIMER_WIDTH defaults to `REG_TIMER_WIDTH, which falls back to 8.

`ifndef REG_TIMER_WIDTH
`define REG_TIMER_WIDTH 8
`endif

module opl_timer_status #(
  parameter int unsigned TIMER_WIDTH = `REG_TIMER_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [7:0]             addr,
  input  logic [7:0]             din,
  input  logic                   overflow1,
  input  logic                   overflow2,
  output logic [TIMER_WIDTH-1:0] timer1_init,
  output logic [TIMER_WIDTH-1:0] timer2_init,
  output logic                   start1,
  output logic                   start2,
  output logic [7:0]             status
`ifdef OPL_IRQ_PIN_EN
  ,
  output logic                   irq_n
`endif
);

  localparam int unsigned AW = 8;
  localparam logic [AW-1:0] ADDR_T1  = AW'(8'h02);
  localparam logic [AW-1:0] ADDR_T2  = AW'(8'h03);
  localparam logic [AW-1:0] ADDR_CTL = AW'(8'h04);

  logic [TIMER_WIDTH-1:0] timer1_init_q, timer1_init_d;
  logic [TIMER_WIDTH-1:0] timer2_init_q, timer2_init_d;
  logic start1_q, start1_d, start2_q, start2_d;
  logic mask1_q, mask1_d, mask2_q, mask2_d;
  logic ovf1_q, ovf1_d, ovf2_q, ovf2_d;
  logic rise1_q, rise1_d, rise2_q, rise2_d;
  logic ft1_q, ft1_d, ft2_q, ft2_d;
  logic irq_q, irq_d;
  logic irq_clr_c, ctl_wr_c;

  // Next-state: write decode, edge pipeline and sticky flag update.
  always_comb begin
    timer1_init_d = timer1_init_q;
    timer2_init_d = timer2_init_q;
    start1_d      = start1_q;
    start2_d      = start2_q;
    mask1_d       = mask1_q;
    mask2_d       = mask2_q;
    ft1_d         = ft1_q;
    ft2_d         = ft2_q;

    irq_clr_c = wr && (addr == ADDR_CTL) && din[7];
    ctl_wr_c  = wr && (addr == ADDR_CTL) && !din[7];

    if (wr && (addr == ADDR_T1)) timer1_init_d = TIMER_WIDTH'(din);
    if (wr && (addr == ADDR_T2)) timer2_init_d = TIMER_WIDTH'(din);
    if (ctl_wr_c) begin
      mask1_d  = din[6];
      mask2_d  = din[5];
      start2_d = din[1];
      start1_d = din[0];
    end

    // Overflow is a level lasting a whole tick; only its rising edge counts.
    // The edge is registered once more so the flag appears one edge later.
    ovf1_d  = overflow1;
    ovf2_d  = overflow2;
    rise1_d = overflow1 & ~ovf1_q;
    rise2_d = overflow2 & ~ovf2_q;

    // Gate with the post-write start/mask so a same-cycle write wins, while
    // an IRQ reset loses to a same-cycle edge (event is not dropped).
    if (irq_clr_c) begin
      ft1_d = 1'b0;
      ft2_d = 1'b0;
    end
    if (rise1_q && start1_d && !mask1_d) ft1_d = 1'b1;
    if (rise2_q && start2_d && !mask2_d) ft2_d = 1'b1;
    if (mask1_d) ft1_d = 1'b0;
    if (mask2_d) ft2_d = 1'b0;

    irq_d = ft1_d | ft2_d;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer1_init_q <= '0;
      timer2_init_q <= '0;
      start1_q      <= 1'b0;
      start2_q      <= 1'b0;
      mask1_q       <= 1'b0;
      mask2_q       <= 1'b0;
      ovf1_q        <= 1'b0;
      ovf2_q        <= 1'b0;
      rise1_q       <= 1'b0;
      rise2_q       <= 1'b0;
      ft1_q         <= 1'b0;
      ft2_q         <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      timer1_init_q <= timer1_init_d;
      timer2_init_q <= timer2_init_d;
      start1_q      <= start1_d;
      start2_q      <= start2_d;
      mask1_q       <= mask1_d;
      mask2_q       <= mask2_d;
      ovf1_q        <= ovf1_d;
      ovf2_q        <= ovf2_d;
      rise1_q       <= rise1_d;
      rise2_q       <= rise2_d;
      ft1_q         <= ft1_d;
      ft2_q         <= ft2_d;
      irq_q         <= irq_d;
    end
  end

`ifdef OPL_IRQ_PIN_EN
  logic irq_n_q;

  // Pin copy of irq, registered alongside it so it adds no latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_n_q <= 1'b1;
    else       irq_n_q <= ~irq_d;
  end

  assign irq_n = irq_n_q;
`endif

  assign timer1_init = timer1_init_q;
  assign timer2_init = timer2_init_q;
  assign start1      = start1_q;
  assign start2      = start2_q;
  assign status      = {irq_q, ft1_q, ft2_q, 5'b0};

endmodule

// File: tb/tb_opl_timer_status.sv
// Testbench for opl_timer_status: directed steps from the test plan followed
// by a randomized phase, all checked against a cycle-level reference model.
module tb_opl_timer_status;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [7:0] addr, din;
  logic       overflow1, overflow2;
  logic [7:0] timer1_init, timer2_init;
  logic       start1, start2;
  logic [7:0] status;
`ifdef OPL_IRQ_PIN_EN
  logic       irq_n;
`endif

  opl_timer_status #(.TIMER_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .wr(wr), .addr(addr), .din(din),
    .overflow1(overflow1), .overflow2(overflow2),
    .timer1_init(timer1_init), .timer2_init(timer2_init),
    .start1(start1), .start2(start2), .status(status)
`ifdef OPL_IRQ_PIN_EN
    , .irq_n(irq_n)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: programmer-visible registers plus, per timer, the last
  // sampled overflow level and a one-deep queue of detected edges (an edge
  // becomes visible on the flag one cycle after it is detected).
  logic [7:0] m_t1, m_t2;
  bit m_s1, m_s2, m_k1, m_k2, m_f1, m_f2;
  bit m_last1, m_last2;
  bit edgeq1[$], edgeq2[$];

  function automatic void model_reset();
    m_t1 = 8'h00; m_t2 = 8'h00;
    m_s1 = 0; m_s2 = 0; m_k1 = 0; m_k2 = 0; m_f1 = 0; m_f2 = 0;
    m_last1 = 0; m_last2 = 0;
    edgeq1 = '{0}; edgeq2 = '{0};
  endfunction

  function automatic bit next_flag(bit f, bit clr, bit ev, bit started, bit masked);
    bit r = clr ? 1'b0 : f;
    if (ev && started && !masked) r = 1'b1;
    if (masked) r = 1'b0;
    return r;
  endfunction

  function automatic void model_step(bit w, logic [7:0] a, logic [7:0] d, bit o1, bit o2);
    bit clr = 0;
    bit ev1, ev2;
    if (w) begin
      case (a)
        8'h02: m_t1 = d;
        8'h03: m_t2 = d;
        8'h04: if (d[7]) clr = 1;
               else begin m_k1 = d[6]; m_k2 = d[5]; m_s2 = d[1]; m_s1 = d[0]; end
        default: ;
      endcase
    end
    ev1 = edgeq1.pop_front();
    ev2 = edgeq2.pop_front();
    edgeq1.push_back(o1 && !m_last1);
    edgeq2.push_back(o2 && !m_last2);
    m_last1 = o1; m_last2 = o2;
    m_f1 = next_flag(m_f1, clr, ev1, m_s1, m_k1);
    m_f2 = next_flag(m_f2, clr, ev2, m_s2, m_k2);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("status", status, {m_f1 | m_f2, m_f1, m_f2, 5'b0});
    chk("timer1_init", timer1_init, m_t1);
    chk("timer2_init", timer2_init, m_t2);
    chk("start1", 8'(start1), 8'(m_s1));
    chk("start2", 8'(start2), 8'(m_s2));
`ifdef OPL_IRQ_PIN_EN
    chk("irq_n", 8'(irq_n), 8'(!(m_f1 | m_f2)));
`endif
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cycle(input bit w, input logic [7:0] a, input logic [7:0] d);
    wr = w; addr = a; din = d;
    @(posedge clk);
    model_step(w, a, d, overflow1, overflow2);
    #1;
    check_all();
    wr = 1'b0;
  endtask

  task automatic wreg(input logic [7:0] a, input logic [7:0] d);
    cycle(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; addr = 8'h00; din = 8'h00;
    overflow1 = 1'b0; overflow2 = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_status", status, 8'h00);
    check_all();

    // Write decode
    wreg(8'h02, 8'hF0);
    wreg(8'h03, 8'h10);
    wreg(8'h04, 8'h03);
    wreg(8'h05, 8'hFF);
    chk("dec_t1", timer1_init, 8'hF0);
    chk("dec_t2", timer2_init, 8'h10);
    chk("dec_starts", {6'b0, start2, start1}, 8'h03);
    chk("dec_status", status, 8'h00);

    // Flag set timer 1: visible two edges after the rise, then held
    overflow1 = 1'b1;
    idle(1);
    chk("ft1_lat1", status, 8'h00);
    idle(1);
    chk("ft1_set", status, 8'hC0);
    idle(200);
    chk("ft1_hold", status, 8'hC0);
    overflow1 = 1'b0;
    idle(1);

    // Flag set timer 2
    overflow2 = 1'b1;
    idle(2);
    chk("ft2_set", status, 8'hE0);
    idle(5);

    // IRQ reset leaves starts alone; held level does not set again
    wreg(8'h04, 8'h80);
    chk("irqrst_status", status, 8'h00);
    chk("irqrst_starts", {6'b0, start2, start1}, 8'h03);
    idle(20);
    chk("no_reset_reedge", status, 8'h00);

    // IRQ reset in the same cycle as an overflow2 edge
    overflow2 = 1'b0;
    overflow1 = 1'b1;
    idle(2);
    chk("ft1_again", status, 8'hC0);
    overflow2 = 1'b1;
    idle(2);
    chk("both_again", status, 8'hE0);
    overflow2 = 1'b0;
    idle(1);
    overflow2 = 1'b1;
    wreg(8'h04, 8'h80);
    idle(1);
    chk("irqrst_with_edge", status, 8'hA0);
    // Same, but the write lands on the cycle the edge reaches the flag
    wreg(8'h04, 8'h80);
    overflow2 = 1'b0;
    idle(1);
    overflow2 = 1'b1;
    idle(1);
    wreg(8'h04, 8'h80);
    chk("irqrst_late_edge", status, 8'hA0);

    // Mask timer 1 (start2 drops, ft2 persists)
    overflow1 = 1'b0;
    wreg(8'h04, 8'h41);
    chk("mask_keep_ft2", status, 8'hA0);
    overflow1 = 1'b1;
    idle(1);
    overflow1 = 1'b0;
    idle(3);
    chk("masked_no_ft1", status, 8'hA0);
    wreg(8'h04, 8'h01);
    idle(3);
    chk("unmask_no_set", status, 8'hA0);

    // Start gating: stopping keeps ft1; stopped timer cannot set it
    overflow1 = 1'b1;
    idle(2);
    chk("ft1_before_stop", status, 8'hE0);
    wreg(8'h04, 8'h00);
    idle(2);
    chk("stop_keeps_ft1", status, 8'hE0);
    overflow1 = 1'b0;
    wreg(8'h04, 8'h80);
    overflow1 = 1'b1;
    idle(3);
    chk("stopped_no_set", status, 8'h00);

    // Async reset mid-run with ft1 set
    overflow1 = 1'b0;
    wreg(8'h02, 8'h5A);
    wreg(8'h04, 8'h01);
    overflow1 = 1'b1;
    idle(2);
    chk("pre_reset_ft1", status, 8'hC0);
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_status", status, 8'h00);
    chk("arst_starts", {6'b0, start2, start1}, 8'h00);
    chk("arst_t1", timer1_init, 8'h00);
`ifdef OPL_IRQ_PIN_EN
    chk("arst_irq_n", 8'(irq_n), 8'h01);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    // overflow1 still high at release: edge seen but timer stopped
    idle(4);
    chk("post_reset_no_set", status, 8'h00);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      bit w;
      logic [7:0] a, d;
      w = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: a = 8'h02;
        1: a = 8'h03;
        2, 3: a = 8'h04;
        default: a = 8'($urandom);
      endcase
      d = 8'($urandom);
      if (a == 8'h04 && $urandom_range(0, 2) != 0) d[6:5] = 2'b00;
      if ($urandom_range(0, 7) == 0) overflow1 = ~overflow1;
      if ($urandom_range(0, 7) == 0) overflow2 = ~overflow2;
      cycle(w, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
